// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory access controller.
// Pure declarations and functions, no logic of its own.
// Size is taken from funct3[1:0]; funct3[2] only selects zero-extension on loads.
package dmem_pkg;

    typedef enum logic [2:0] {
        RW_B  = 3'b000,
        RW_H  = 3'b001,
        RW_W  = 3'b010,
        RW_BU = 3'b100,
        RW_HU = 3'b101
    } rw_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } dmem_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Byte enables for an access; halves only look at a[1], words ignore a[1:0].
    function automatic logic [3:0] lane_be(input logic [2:0] rw_type, input logic [1:0] a);
        logic [3:0] be;
        case (rw_type[1:0])
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_wdata(input logic [2:0] rw_type, input logic [31:0] d);
        logic [31:0] w;
        case (rw_type[1:0])
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Natural alignment check: halves need a[0]==0, words need a[1:0]==0.
    function automatic logic misaligned(input logic [2:0] rw_type, input logic [1:0] a);
        logic m;
        case (rw_type[1:0])
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/grant/rvalid data bus between the access controller and memory.
// The controller is the master; the memory or bus fabric is the slave.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              dbus_req;
    logic              dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [3:0]        dbus_be;
    logic [31:0]       dbus_wdata;
    logic              dbus_gnt;
    logic              dbus_rvalid;
    logic [31:0]       dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half from a read word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_rw_type,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    // Lane select followed by extension according to the access type
    always_comb begin
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_sext = ~i_rw_type[2];
        case (i_rw_type[1:0])
            SZ_BYTE: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{w_sext & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// Purpose: MEM-stage data-memory controller driving a req/gnt/rvalid bus (optional DMEM_MISALIGN_EXC_EN).
// Latency: load >= 4 cycles (IDLE, REQ, WAIT, DONE), store >= 3 cycles (IDLE, REQ, DONE).
// Backpressure: stall held until DONE; bus request held stable until dbus_gnt, then waits for dbus_rvalid on loads.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  addr_out,
    input  logic               MemRW,
    input  logic [2:0]         RWType,
    input  logic [31:0]        data_out,
    output logic [31:0]        data_in,
    output logic               stall,
    output logic               misalign_exc,
    dmem_access_ctrl_if.master dbus
);
    dmem_state_e       r_state;
    dmem_state_e       w_next_state;
    logic              r_dbus_req;
    logic              r_dbus_we;
    logic [ADDR_W-1:0] r_dbus_addr;
    logic [3:0]        r_dbus_be;
    logic [31:0]       r_dbus_wdata;
    logic [2:0]        r_type;
    logic [1:0]        r_lane;
    logic [31:0]       r_data_in;
    logic [31:0]       w_load_fmt;
    logic              w_start;
    logic              w_misalign;
    logic              w_issue;
    logic              w_grant;
    logic              w_capture;

    assign w_start = req_valid & ~flush;

`ifdef DMEM_MISALIGN_EXC_EN
    logic r_misalign;

    assign w_misalign   = misaligned(RWType, addr_out[1:0]);
    assign misalign_exc = r_misalign;

    // Misaligned access bypasses the bus; flag it during the DONE cycle only
    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= (r_state == S_IDLE) & w_start & w_misalign;
    end
`else
    assign w_misalign   = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    // Next state plus the single-cycle events that load the datapath registers
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) begin
                w_next_state = w_misalign ? S_DONE : S_REQ;
                w_issue      = ~w_misalign;
            end
            S_REQ: if (dbus.dbus_gnt) begin
                // A same-cycle rvalid is not read data; loads always pass through WAIT
                w_next_state = r_dbus_we ? S_DONE : S_WAIT;
                w_grant      = 1'b1;
            end
            S_WAIT: if (dbus.dbus_rvalid) begin
                w_next_state = S_DONE;
                w_capture    = 1'b1;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Bus request registers: loaded on issue, held through REQ, zeroed once granted
    always_ff @(posedge clk) begin
        if (rst || w_grant) begin
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_dbus_addr  <= '0;
            r_dbus_be    <= 4'b0000;
            r_dbus_wdata <= '0;
        end else if (w_issue) begin
            r_dbus_req   <= 1'b1;
            r_dbus_we    <= MemRW;
            r_dbus_addr  <= {addr_out[ADDR_W-1:2], 2'b00};
            r_dbus_be    <= lane_be(RWType, addr_out[1:0]);
            r_dbus_wdata <= MemRW ? store_wdata(RWType, data_out) : 32'h0;
        end
    end

    // Type and byte offset survive the grant so the WAIT capture can format the data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_type <= 3'b000;
            r_lane <= 2'b00;
        end else if (w_issue) begin
            r_type <= RWType;
            r_lane <= addr_out[1:0];
        end
    end

    dmem_load_align u_load_align (
        .i_rdata   (dbus.dbus_rdata),
        .i_addr    (r_lane),
        .i_rw_type (r_type),
        .o_data    (w_load_fmt)
    );

    // Load result register: only a WAIT-state rvalid updates it
    always_ff @(posedge clk) begin
        if (rst)            r_data_in <= 32'h0;
        else if (w_capture) r_data_in <= w_load_fmt;
    end

    assign stall           = req_valid & (r_state != S_DONE);
    assign data_in         = r_data_in;
    assign dbus.dbus_req   = r_dbus_req;
    assign dbus.dbus_we    = r_dbus_we;
    assign dbus.dbus_addr  = r_dbus_addr;
    assign dbus.dbus_be    = r_dbus_be;
    assign dbus.dbus_wdata = r_dbus_wdata;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table, corner sequences, random vs. reference model.
// The bench plays the memory slave with programmable grant and read-data delays.
// Build with or without DMEM_MISALIGN_EXC_EN; expectations follow the same macro.
module tb_dmem_access_ctrl;

    typedef struct {
        logic        we;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gd;
        int          rvd;
        bit          fl;
        bit          erv;
        logic [31:0] exp_din;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_stall;
        bit          exp_mis;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        flush;
    logic [31:0] addr_out;
    logic        MemRW;
    logic [2:0]  RWType;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        stall;
    logic        misalign_exc;

    int          n_tests;
    int          n_fail;
    logic [31:0] model_din;

    dmem_access_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_access_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .flush        (flush),
        .addr_out     (addr_out),
        .MemRW        (MemRW),
        .RWType       (RWType),
        .data_out     (data_out),
        .data_in      (data_in),
        .stall        (stall),
        .misalign_exc (misalign_exc),
        .dbus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int sz_bytes(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int lane_off(input logic [2:0] t, input logic [31:0] a);
        int s;
        s = sz_bytes(t);
        if (s == 4) return 0;
        return (int'(a % 4) / s) * s;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
        int b;
        b = ((1 << sz_bytes(t)) - 1) << lane_off(t, a);
        return b[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] d);
        case (sz_bytes(t))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        longint unsigned v;
        int s;
        s = sz_bytes(t);
        v = (longint'(rd) >> (8 * lane_off(t, a))) & ((64'd1 << (8 * s)) - 1);
        if (s < 4 && t[2] == 1'b0 && v >= (64'd1 << (8 * s - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    function automatic bit model_mis(input logic [2:0] t, input logic [31:0] a);
`ifdef DMEM_MISALIGN_EXC_EN
        return (sz_bytes(t) > 1) && ((a % sz_bytes(t)) != 0);
`else
        return (t === 3'bxxx) && (a === 32'hx);
`endif
    endfunction

    // Builds a fully expected vector from the model and the running data_in value
    function automatic vec_t model_vec(input logic we, input logic [2:0] t, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [31:0] rd,
                                       input int gd, input int rvd, input bit fl, input bit erv);
        vec_t v;
        v = '{we, t, a, wd, rd, gd, rvd, fl, erv, model_din, model_be(t, a), a & 32'hFFFF_FFFC,
              model_wdata(t, wd), 0, model_mis(t, a)};
        if (v.exp_mis)  v.exp_stall = 1;
        else if (we)    v.exp_stall = gd + 2;
        else begin
            v.exp_stall = gd + rvd + 3;
            v.exp_din   = model_load(t, a, rd);
        end
        return v;
    endfunction

    // ---------------- pipeline driver + memory slave ----------------
    task automatic run_access(input vec_t v, output int ns, output int nr, output logic [3:0] be0,
                              output logic [31:0] a0, output logic [31:0] w0, output logic we0,
                              output bit unst, output logic [31:0] din, output logic mis,
                              output int nm, output bit tmo);
        int  waitc;
        bit  granted;
        bit  done;
        ns = 0; nr = 0; nm = 0; waitc = 0; granted = 0; done = 0; unst = 0;
        be0 = 4'h0; a0 = 32'h0; w0 = 32'h0; we0 = 1'b0; din = 32'h0; mis = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; MemRW = v.we; RWType = v.t; addr_out = v.a; data_out = v.wd; flush = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (v.fl) flush = 1'b1;
            end
            #1;
            bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0; bus.dbus_rdata = $urandom;
            if (misalign_exc) nm++;
            if (!stall) begin
                done = 1; din = data_in; mis = misalign_exc;
            end else begin
                ns++;
                if (bus.dbus_req) begin
                    if (nr == 0) begin
                        be0 = bus.dbus_be; a0 = bus.dbus_addr; w0 = bus.dbus_wdata; we0 = bus.dbus_we;
                    end else if (bus.dbus_be !== be0 || bus.dbus_addr !== a0 ||
                                 bus.dbus_wdata !== w0 || bus.dbus_we !== we0) begin
                        unst = 1;
                    end
                    nr++;
                    if (nr > v.gd) begin
                        bus.dbus_gnt = 1'b1; granted = 1;
                        if (v.erv) begin bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'hBAD0_BAD0; end
                    end
                end else if (granted) begin
                    waitc++;
                    if (waitc > v.rvd) begin bus.dbus_rvalid = 1'b1; bus.dbus_rdata = v.rd; end
                end
            end
        end
        req_valid = 1'b0; flush = 1'b0; bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0;
        tmo = !done;
        if (tmo) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic exec_and_check(input string tag, input vec_t v);
        int          ns, nr, nm;
        logic [3:0]  be0;
        logic [31:0] a0, w0, din;
        logic        we0, mis;
        bit          unst, tmo;
        run_access(v, ns, nr, be0, a0, w0, we0, unst, din, mis, nm, tmo);
        if (tmo) begin
            n_tests++; n_fail++;
            $display("FAIL %s.timeout: access did not complete within 60 cycles", tag);
            model_din = 32'h0;
            return;
        end
        check({tag, ".stall_cycles"}, ns, v.exp_stall);
        check({tag, ".req_cycles"}, nr, v.exp_mis ? 0 : v.gd + 1);
        if (!v.exp_mis) begin
            check({tag, ".be"}, {28'h0, be0}, {28'h0, v.exp_be});
            check({tag, ".addr"}, a0, v.exp_addr);
            check({tag, ".we"}, {31'h0, we0}, {31'h0, v.we});
            check({tag, ".bus_stable"}, {31'h0, unst}, 32'h0);
            if (v.we) check({tag, ".wdata"}, w0, v.exp_wdata);
        end
        check({tag, ".data_in"}, din, v.exp_din);
        check({tag, ".misalign_at_done"}, {31'h0, mis}, {31'h0, v.exp_mis});
        check({tag, ".misalign_cycles"}, nm, v.exp_mis ? 1 : 0);
        model_din = v.exp_din;
    endtask

    vec_t        tbl[12];
    logic [2:0]  types[5];
    vec_t        mv;

    initial begin
        n_tests = 0; n_fail = 0; model_din = 32'h0;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; addr_out = 32'h0; MemRW = 1'b0;
        RWType = 3'b000; data_out = 32'h0;
        bus.dbus_gnt = 1'b0; bus.dbus_rvalid = 1'b0; bus.dbus_rdata = 32'h0;

        //        we    type    addr          wdata         rdata        gd rvd fl erv  exp_din       be       addr          wdata         stall mis
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h100, 32'h0,        3, 0};
        tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 0, 0, 0, 32'hFFFFFF80, 4'b1000, 32'h100, 32'h0,        3, 0};
        tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 0, 0, 0, 32'h00000080, 4'b1000, 32'h100, 32'h0,        3, 0};
        tbl[3]  = '{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        3, 0, 0, 0, 32'h00000080, 4'b1100, 32'h200, 32'hABCDABCD, 5, 0};
        tbl[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 1, 0, 0, 0, 32'hFFFF8001, 4'b1100, 32'h100, 32'h0,        4, 0};
        tbl[5]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 0, 2, 0, 0, 32'h0000F00D, 4'b0011, 32'h100, 32'h0,        5, 0};
        tbl[6]  = '{1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0,        0, 0, 0, 0, 32'h0000F00D, 4'b0010, 32'h100, 32'hA5A5A5A5, 2, 0};
        tbl[7]  = '{1'b1, 3'b010, 32'h30C, 32'h01234567, 32'h0,        1, 0, 0, 0, 32'h0000F00D, 4'b1111, 32'h30C, 32'h01234567, 3, 0};
        tbl[8]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2, 1, 0, 0, 32'h0000007F, 4'b0010, 32'h100, 32'h0,        6, 0};
        tbl[9]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h00008000, 0, 0, 0, 0, 32'hFFFF8000, 4'b0011, 32'h100, 32'h0,        3, 0};
        tbl[10] = '{1'b0, 3'b010, 32'h204, 32'h0,        32'hCAFEF00D, 1, 1, 1, 0, 32'hCAFEF00D, 4'b1111, 32'h204, 32'h0,        5, 0};
        tbl[11] = '{1'b0, 3'b100, 32'h202, 32'h0,        32'h00AB0000, 0, 1, 0, 1, 32'h000000AB, 4'b0100, 32'h200, 32'h0,        4, 0};

        // Reset state, including stall following req_valid while in reset
        repeat (2) @(negedge clk);
        #1;
        check("rst.dbus_req", {31'h0, bus.dbus_req}, 32'h0);
        check("rst.dbus_we", {31'h0, bus.dbus_we}, 32'h0);
        check("rst.dbus_addr", bus.dbus_addr, 32'h0);
        check("rst.dbus_be", {28'h0, bus.dbus_be}, 32'h0);
        check("rst.dbus_wdata", bus.dbus_wdata, 32'h0);
        check("rst.data_in", data_in, 32'h0);
        check("rst.misalign", {31'h0, misalign_exc}, 32'h0);
        check("rst.stall_low", {31'h0, stall}, 32'h0);
        req_valid = 1'b1;
        #1;
        check("rst.stall_follows", {31'h0, stall}, 32'h1);
        @(negedge clk);
        #1;
        check("rst.no_req_in_reset", {31'h0, bus.dbus_req}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Flush in IDLE suppresses the request
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; MemRW = 1'b0; RWType = 3'b010; addr_out = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("flush_idle.no_req%0d", i), {31'h0, bus.dbus_req}, 32'h0);
            check($sformatf("flush_idle.stall%0d", i), {31'h0, stall}, 32'h1);
        end
        req_valid = 1'b0; flush = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) exec_and_check($sformatf("row%0d", i), tbl[i]);

        // Misaligned word load
`ifdef DMEM_MISALIGN_EXC_EN
        mv = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 0, 0, model_din, 4'b0000, 32'h0, 32'h0, 1, 1};
`else
        mv = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 0, 0, 32'h11223344, 4'b1111, 32'h100, 32'h0, 3, 0};
`endif
        exec_and_check("misalign_lw", mv);

        // Reset while in WAIT abandons the load; stray rvalid afterwards is ignored
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b0; MemRW = 1'b0; RWType = 3'b010; addr_out = 32'h80;
        @(negedge clk);
        #1;
        check("rstwait.req_issued", {31'h0, bus.dbus_req}, 32'h1);
        bus.dbus_gnt = 1'b1;
        @(negedge clk);
        bus.dbus_gnt = 1'b0;
        #1;
        check("rstwait.req_dropped_on_gnt", {31'h0, bus.dbus_req}, 32'h0);
        check("rstwait.stall_in_wait", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("rstwait.req_after", {31'h0, bus.dbus_req}, 32'h0);
        check("rstwait.data_in_cleared", data_in, 32'h0);
        bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'h55AA55AA;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rstwait.stray_rvalid%0d", i), data_in, 32'h0);
            check($sformatf("rstwait.idle_stall%0d", i), {31'h0, stall}, 32'h0);
        end
        bus.dbus_rvalid = 1'b0;
        model_din = 32'h0;

        // Random accesses against the reference model
        types[0] = 3'b000; types[1] = 3'b001; types[2] = 3'b010; types[3] = 3'b100; types[4] = 3'b101;
        for (int i = 0; i < 40; i++) begin
            mv = model_vec(1'($urandom_range(0, 1)), types[$urandom_range(0, 4)],
                           32'h1000 + 32'($urandom_range(0, 63)), $urandom, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            exec_and_check($sformatf("rnd%0d", i), mv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Multi-cycle data-memory access controller on the provider side of the MEM stage's memory port. It consumes address, write enable, access type and store data, and drives a req/gnt/rvalid data bus. It stalls the pipeline until the access completes, then returns the aligned, extended load value as `data_in`. It sits between the MEM stage and the external data memory/bus.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a load or store is present in MEM this cycle.
- `flush` in 1: kill the pending access. Honoured only in IDLE.
- `addr_out` in ADDR_W: byte address (ALU result).
- `MemRW` in 1: 1 = store, 0 = load.
- `RWType` in 3: funct3 encoding. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `data_out` in 32: store data, right-justified.
- `data_in` out 32: formatted load result.
- `stall` out 1: hold IF/ID/EX/MEM.
- `misalign_exc` out 1: one-cycle misaligned-access pulse.
- `dbus_req` out 1, `dbus_we` out 1, `dbus_addr` out ADDR_W (word-aligned), `dbus_be` out 4, `dbus_wdata` out 32: bus request.
- `dbus_gnt` in 1, `dbus_rvalid` in 1, `dbus_rdata` in 32: bus response.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on `req_valid & ~flush`, latch address, type, RW flag and store data, then go to REQ.
- REQ: hold `dbus_req`=1 and keep all bus outputs stable until `dbus_gnt`. On a granted store, go to DONE. On a granted load, go to WAIT.
- WAIT: on `dbus_rvalid`, capture formatted `dbus_rdata` into `data_in`, then go to DONE.
- DONE: `stall`=0 for exactly one cycle, so the pipeline advances. Then go to IDLE.
- `stall` = `req_valid & (state != DONE)`. It is combinational.
- Lanes from `addr[1:0]`:
  - B: `be` = 0001 << a.
  - H: `be` = 0011 << {a[1],0}.
  - W: `be` = 1111.
  - `dbus_wdata` replicates the byte or half across all lanes.
- Load formatting selects the byte or half by address. B and H sign-extend; BU and HU zero-extend; W passes through unchanged.
- `data_in` holds its value until the next load capture. Stores never change it.
- `flush` in REQ or WAIT is ignored: a granted or issued access always completes.
- `rst` in any state forces IDLE and drops `dbus_req` the same edge. A request in flight is abandoned, and `dbus_rvalid` arriving in IDLE is ignored.
- `dbus_gnt` and `dbus_rvalid` in the same cycle while in REQ (load): treat as grant only. Read data is expected from WAIT onward.

## Timing
- Reset values:
  - state IDLE.
  - `data_in` 0.
  - `dbus_req`, `dbus_we` 0.
  - `dbus_addr`, `dbus_wdata` 0.
  - `dbus_be` 0000.
  - `misalign_exc` 0.
  - `stall` follows `req_valid`.
- Load with gnt at first REQ cycle and rvalid the next cycle: IDLE(c0), REQ(c1), WAIT(c2), DONE(c3). `stall` is high c0–c2. `data_in` is valid from c3.
- Store with immediate gnt: IDLE, REQ, DONE, so 2 stall cycles.
- Back-to-back memory ops: IDLE is re-entered the cycle after DONE, so each access costs at least one IDLE cycle.
- Bus outputs are registered. They are valid only while `dbus_req`=1 and are zero otherwise.

## Configuration
- `DMEM_MISALIGN_EXC_EN` defined:
  - Misaligned accesses are detected in IDLE: H/HU with `a[0]`≠0, or W with `a[1:0]`≠0.
  - Such an access skips the bus and goes straight to DONE with `misalign_exc`=1 for that DONE cycle.
  - `data_in` is unchanged.
- Not defined:
  - No detection. `misalign_exc` is tied 0.
  - H/HU use `a[1]` only; W ignores `a[1:0]`. The access is issued as aligned.

## Structure
- `dmem_pkg` holds:
  - `rw_type_e` (B=3'b000, H=3'b001, W=3'b010, BU=3'b100, HU=3'b101).
  - `dmem_state_e`.
  - the lane/byte-enable helper function.
- Sub-module `dmem_load_align`: purely combinational. Takes `rdata`, `addr[1:0]` and type, and returns the formatted 32-bit value. It is instantiated once and used at WAIT capture.

## Test plan
- LW at 0x100, gnt at first REQ cycle, rvalid next cycle with 0xDEADBEEF → `stall` high for 3 cycles, `data_in`=0xDEADBEEF in DONE, `dbus_be`=1111, `dbus_addr`=0x100.
- LB at 0x103, rdata 0x80112233 → `be`=1000, `data_in`=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH at 0x202, `data_out`=0x0000ABCD, gnt delayed 3 cycles → `dbus_req` held for 4 cycles with stable `addr`=0x200, `be`=1100, `wdata`=0xABCDABCD. `data_in` unchanged.
- `flush` with `req_valid` in IDLE → no `dbus_req`. `flush` while in WAIT → access completes and DONE occurs.
- `rst` asserted in WAIT → next cycle IDLE, `dbus_req`=0. A later stray `rvalid` does not change `data_in`=0.
- With `DMEM_MISALIGN_EXC_EN`, LW at 0x101 → no bus request, `misalign_exc` pulses 1 cycle after 1 stall cycle. Without the macro → aligned LW issued at 0x100.
